// File: rtl/wb_stream_writer_ctrl_if.sv
// Wishbone classic/burst read bus between the stream writer and a memory slave.
interface wb_stream_writer_ctrl_if #(
    parameter int unsigned WB_AW = 32,
    parameter int unsigned WB_DW = 32
) ();
    logic [WB_AW-1:0]   wbm_adr_o;
    logic [WB_DW/8-1:0] wbm_sel_o;
    logic               wbm_we_o;
    logic               wbm_cyc_o;
    logic               wbm_stb_o;
    logic [2:0]         wbm_cti_o;
    logic [1:0]         wbm_bte_o;
    logic [WB_DW-1:0]   wbm_dat_i;
    logic               wbm_ack_i;
    logic               wbm_err_i;

    modport master (
        output wbm_adr_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i
    );

    modport slave (
        input  wbm_adr_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i
    );
endinterface

// File: rtl/wb_stream_writer_ctrl.sv
// Reads a circular memory buffer in Wishbone bursts and pushes each word into a downstream FIFO.
module wb_stream_writer_ctrl #(
    parameter int unsigned WB_AW   = 32,
    parameter int unsigned WB_DW   = 32,
    parameter int unsigned FIFO_AW = 5
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic                 enable,
    input  logic [WB_AW-1:0]     start_adr,
    input  logic [WB_AW-1:0]     buf_size,
    input  logic [WB_AW-1:0]     burst_size,
    wb_stream_writer_ctrl_if.master wbm,
    output logic [WB_DW-1:0]     fifo_d,
    output logic                 fifo_wr,
    input  logic [FIFO_AW:0]     fifo_free,
    output logic                 busy,
    output logic                 irq,
    output logic                 err
);
    localparam int unsigned BPW = WB_DW / 8;
    localparam int unsigned BSH = $clog2(BPW);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WB_AW-1:0] r_ofs;
    logic [WB_AW-1:0] r_beat;
    logic [WB_AW-1:0] r_blen;
    logic [WB_AW-1:0] r_start;
    logic [WB_AW-1:0] r_buf;
    logic             r_irq;
    logic             r_err;

    logic             w_start;
    logic [WB_AW-1:0] w_ofs_eff;
    logic [WB_AW-1:0] w_rem;
    logic [WB_AW-1:0] w_blen;
    logic             w_fifo_ok;
    logic             w_in_burst;
    logic             w_err_hit;
    logic             w_ack_hit;
    logic             w_last;
    logic [WB_AW-1:0] w_ofs_inc;

    // Burst sizing from live configuration; a shrunken buffer restarts from offset 0
    always_comb begin
        w_start    = enable && (buf_size != '0) && (burst_size != '0);
        w_ofs_eff  = (r_ofs >= buf_size) ? '0 : r_ofs;
        w_rem      = buf_size - w_ofs_eff;
        w_blen     = (burst_size < w_rem) ? burst_size : w_rem;
        w_fifo_ok  = WB_AW'(fifo_free) >= w_blen;
        w_in_burst = (r_state == S_BURST);
        w_err_hit  = w_in_burst && wbm.wbm_err_i;
        w_ack_hit  = w_in_burst && wbm.wbm_ack_i && !wbm.wbm_err_i;
        w_last     = (r_beat == (r_blen - WB_AW'(1)));
        w_ofs_inc  = r_ofs + WB_AW'(1);
    end

    // State register
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; an error ends the pass regardless of enable
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!enable) begin
                    w_state_next = S_IDLE;
                end else if ((w_blen != '0) && w_fifo_ok) begin
                    w_state_next = S_BURST;
                end
            end
            S_BURST: begin
                if (w_err_hit) begin
                    w_state_next = S_IDLE;
                end else if (w_ack_hit && w_last) begin
                    w_state_next = enable ? S_WAIT : S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output decode: bus qualifiers from state, zero-latency FIFO write on ack
    always_comb begin
        wbm.wbm_adr_o = '0;
        wbm.wbm_sel_o = '0;
        wbm.wbm_we_o  = 1'b0;
        wbm.wbm_cyc_o = 1'b0;
        wbm.wbm_stb_o = 1'b0;
        wbm.wbm_cti_o = 3'b000;
        wbm.wbm_bte_o = 2'b00;
        fifo_wr       = 1'b0;
        fifo_d        = '0;
        busy          = (r_state != S_IDLE);
        if (w_in_burst) begin
            wbm.wbm_cyc_o = 1'b1;
            wbm.wbm_stb_o = 1'b1;
            wbm.wbm_sel_o = {BPW{1'b1}};
            wbm.wbm_adr_o = r_start + (r_ofs << BSH);
            wbm.wbm_cti_o = w_last ? 3'b111 : 3'b010;
        end
        if (w_ack_hit) begin
            fifo_wr = 1'b1;
            fifo_d  = wbm.wbm_dat_i;
        end
    end

    // Datapath: offset/beat tracking, config capture at burst start, irq and sticky error
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_ofs   <= '0;
            r_beat  <= '0;
            r_blen  <= '0;
            r_start <= '0;
            r_buf   <= '0;
            r_irq   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_irq <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_ofs <= '0;
                        r_err <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (w_state_next == S_BURST) begin
                        r_ofs   <= w_ofs_eff;
                        r_blen  <= w_blen;
                        r_start <= start_adr;
                        r_buf   <= buf_size;
                        r_beat  <= '0;
                    end
                end
                S_BURST: begin
                    if (w_err_hit) begin
                        r_err <= 1'b1;
                    end else if (w_ack_hit) begin
                        r_beat <= r_beat + WB_AW'(1);
                        if (w_ofs_inc == r_buf) begin
                            r_ofs <= '0;
                            r_irq <= 1'b1;
                        end else begin
                            r_ofs <= w_ofs_inc;
                        end
                    end
                end
                default: begin
                    r_irq <= 1'b0;
                end
            endcase
        end
    end

    assign irq = r_irq;
    assign err = r_err;
endmodule

// File: tb/tb_wb_stream_writer_ctrl.sv
// Scoreboard bench: a buffer/burst model predicts every beat; a monitor checks beats, FIFO writes and irq.
module tb_wb_stream_writer_ctrl;
    localparam int unsigned WB_AW   = 32;
    localparam int unsigned WB_DW   = 32;
    localparam int unsigned FIFO_AW = 5;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               enable;
    logic [WB_AW-1:0]   start_adr;
    logic [WB_AW-1:0]   buf_size;
    logic [WB_AW-1:0]   burst_size;
    logic [WB_DW-1:0]   fifo_d;
    logic               fifo_wr;
    logic [FIFO_AW:0]   fifo_free;
    logic               busy;
    logic               irq;
    logic               err;

    wb_stream_writer_ctrl_if #(.WB_AW(WB_AW), .WB_DW(WB_DW)) wbm_if ();

    wb_stream_writer_ctrl #(.WB_AW(WB_AW), .WB_DW(WB_DW), .FIFO_AW(FIFO_AW)) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .enable     (enable),
        .start_adr  (start_adr),
        .buf_size   (buf_size),
        .burst_size (burst_size),
        .wbm        (wbm_if),
        .fifo_d     (fifo_d),
        .fifo_wr    (fifo_wr),
        .fifo_free  (fifo_free),
        .busy       (busy),
        .irq        (irq),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [2:0]  cti;
        bit          irq;
    } beat_t;

    beat_t       exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          popped = 0;
    int          n_wr = 0;
    int          run_last_first = 0;
    int unsigned ack_pct = 100;
    bit          spurious = 1'b0;
    int          err_beat = -1;
    bit          rand_free = 1'b0;
    logic [FIFO_AW:0] free_fixed = 6'd32;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: walk the circular buffer in bursts of min(burst, remaining)
    task automatic push_run(input logic [31:0] sa, input int bsz, input int brst, input int nb,
                            output int last_first);
        int ofs = 0;
        int blen;
        last_first = 0;
        for (int b = 0; b < nb; b++) begin
            blen = (brst < bsz - ofs) ? brst : bsz - ofs;
            if (b == nb - 1) last_first = popped + exp_q.size();
            for (int i = 0; i < blen; i++) begin
                beat_t e;
                e.adr = sa + 32'(ofs * 4);
                e.cti = (i == blen - 1) ? 3'b111 : 3'b010;
                ofs++;
                e.irq = (ofs == bsz);
                if (ofs == bsz) ofs = 0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic start_run(input logic [31:0] sa, input int bsz, input int brst, input int nb);
        start_adr  = sa;
        buf_size   = 32'(bsz);
        burst_size = 32'(brst);
        push_run(sa, bsz, brst, nb, run_last_first);
        enable = 1'b1;
    endtask

    // Drop enable once the last predicted burst has begun, then let it drain
    task automatic finish_run();
        int n = 0;
        while (popped <= run_last_first && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        chk("run_progress", 64'(popped > run_last_first), 64'd1);
        enable = 1'b0;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("busy_after_run", 64'(busy), 64'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        #1;
    endtask

    // Slave: random wait states, optional error injection, spurious acks while idle
    initial begin
        int nbeat = 0;
        bit last_stb = 1'b0;
        wbm_if.wbm_ack_i = 1'b0;
        wbm_if.wbm_err_i = 1'b0;
        wbm_if.wbm_dat_i = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                wbm_if.wbm_ack_i = 1'b0;
                wbm_if.wbm_err_i = 1'b0;
                nbeat = 0;
                last_stb = 1'b0;
            end else begin
                if (wbm_if.wbm_ack_i && !wbm_if.wbm_err_i && last_stb) nbeat++;
                last_stb = wbm_if.wbm_cyc_o && wbm_if.wbm_stb_o;
                if (!last_stb) nbeat = 0;
                if (last_stb) begin
                    if (err_beat >= 0 && nbeat == err_beat) begin
                        wbm_if.wbm_err_i = 1'b1;
                        wbm_if.wbm_ack_i = 1'b1;
                    end else begin
                        wbm_if.wbm_err_i = 1'b0;
                        wbm_if.wbm_ack_i = ($urandom_range(99, 0) < ack_pct);
                    end
                end else begin
                    wbm_if.wbm_err_i = 1'b0;
                    wbm_if.wbm_ack_i = spurious && ($urandom_range(3, 0) == 0);
                end
                wbm_if.wbm_dat_i = $urandom;
            end
        end
    end

    // FIFO free-space driver
    initial begin
        fifo_free = '0;
        forever begin
            @(negedge clk); #2;
            fifo_free = rand_free ? 6'($urandom_range(63, 0)) : free_fixed;
        end
    end

    // Monitor: pops one expectation per accepted beat and checks irq one cycle later
    initial begin
        bit exp_irq = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_irq = 1'b0;
            end else begin
                bit    beat;
                bit    irq_next;
                beat_t e;
                irq_next = 1'b0;
                beat = wbm_if.wbm_stb_o && wbm_if.wbm_ack_i && !wbm_if.wbm_err_i;
                chk("irq", 64'(irq), 64'(exp_irq));
                if (fifo_wr) n_wr++;
                if (beat) begin
                    chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        popped++;
                        chk("adr", 64'(wbm_if.wbm_adr_o), 64'(e.adr));
                        chk("cti", 64'(wbm_if.wbm_cti_o), 64'(e.cti));
                        chk("cyc", 64'(wbm_if.wbm_cyc_o), 64'd1);
                        chk("sel", 64'(wbm_if.wbm_sel_o), 64'hf);
                        chk("we_bte", 64'({wbm_if.wbm_we_o, wbm_if.wbm_bte_o}), 64'd0);
                        chk("fifo_wr", 64'(fifo_wr), 64'd1);
                        chk("fifo_d", 64'(fifo_d), 64'(wbm_if.wbm_dat_i));
                        irq_next = e.irq;
                    end
                end else begin
                    chk("fifo_wr_idle", 64'(fifo_wr), 64'd0);
                end
                exp_irq = irq_next;
            end
        end
    end

    initial begin
        int n;
        int ncyc;
        int nwr0;
        enable = 1'b0;
        start_adr = '0;
        buf_size = '0;
        burst_size = '0;
        #12;
        // Reset values
        chk("rst_cyc_stb", 64'({wbm_if.wbm_cyc_o, wbm_if.wbm_stb_o}), 64'd0);
        chk("rst_cti_bte", 64'({wbm_if.wbm_cti_o, wbm_if.wbm_bte_o}), 64'd0);
        chk("rst_adr", 64'(wbm_if.wbm_adr_o), 64'd0);
        chk("rst_sel_we", 64'({wbm_if.wbm_sel_o, wbm_if.wbm_we_o}), 64'd0);
        chk("rst_fifo", 64'({fifo_wr, fifo_d}), 64'd0);
        chk("rst_status", 64'({busy, irq, err}), 64'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;

        // Two 4-beat bursts over an 8-word buffer, then wrap to base
        ack_pct = 100;
        start_run(32'h1000, 8, 4, 3);
        finish_run();

        // 6-word buffer: bursts of 4 then 2, then wrap
        ack_pct = 70;
        start_run(32'h1000, 6, 4, 3);
        finish_run();

        // Hold in WAIT while the FIFO lacks room for a full burst
        free_fixed = 6'd3;
        @(negedge clk); #1;
        start_run(32'h1000, 8, 4, 1);
        repeat (10) @(negedge clk);
        #1;
        chk("wait_hold_cyc", 64'(wbm_if.wbm_cyc_o), 64'd0);
        chk("wait_hold_busy", 64'(busy), 64'd1);
        free_fixed = 6'd4;
        @(negedge clk); #1;
        chk("wait_release_cyc", 64'(wbm_if.wbm_cyc_o), 64'd1);
        free_fixed = 6'd32;
        finish_run();

        // Error on beat 2 (ack asserted too): one write, abort to IDLE, sticky err
        ack_pct = 100;
        err_beat = 1;
        start_adr = 32'h1000;
        buf_size = 32'd8;
        burst_size = 32'd4;
        exp_q.push_back('{32'h1000, 3'b010, 1'b0});
        run_last_first = popped;
        nwr0 = n_wr;
        enable = 1'b1;
        n = 0;
        while (popped <= run_last_first && n < 200) begin @(negedge clk); #1; n++; end
        enable = 1'b0;
        n = 0;
        while (!(wbm_if.wbm_err_i && wbm_if.wbm_stb_o) && n < 200) begin @(negedge clk); #1; n++; end
        chk("err_seen", 64'(wbm_if.wbm_err_i && wbm_if.wbm_stb_o), 64'd1);
        @(negedge clk); #1;
        chk("err_cyc_drop", 64'(wbm_if.wbm_cyc_o), 64'd0);
        chk("err_flag", 64'(err), 64'd1);
        chk("err_idle", 64'(busy), 64'd0);
        chk("err_writes", 64'(n_wr - nwr0), 64'd1);
        err_beat = -1;
        repeat (3) @(negedge clk);
        #1;
        chk("err_sticky", 64'(err), 64'd1);
        start_run(32'h1000, 8, 4, 1);
        @(negedge clk); #1;
        chk("err_cleared", 64'(err), 64'd0);
        finish_run();

        // Enable dropped on first beat: burst still completes
        ack_pct = 50;
        start_run(32'h2000, 8, 4, 1);
        finish_run();

        // Zero buffer size never starts a cycle
        start_adr = 32'h1000;
        buf_size = '0;
        burst_size = 32'd4;
        enable = 1'b1;
        ncyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (wbm_if.wbm_cyc_o) ncyc++;
        end
        chk("buf0_no_cyc", 64'(ncyc), 64'd0);
        chk("buf0_busy", 64'(busy), 64'd0);
        enable = 1'b0;

        // Asynchronous reset in the middle of a burst
        ack_pct = 100;
        start_run(32'h1000, 8, 4, 2);
        n = 0;
        while (!wbm_if.wbm_cyc_o && n < 100) begin @(negedge clk); #1; n++; end
        chk("rst_mid_cyc_pre", 64'(wbm_if.wbm_cyc_o), 64'd1);
        chk("rst_mid_wr_pre", 64'(fifo_wr), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_cyc", 64'(wbm_if.wbm_cyc_o), 64'd0);
        chk("rst_mid_fifo_wr", 64'(fifo_wr), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        exp_q.delete();
        enable = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;

        // Randomized buffers, bursts, wait states, FIFO space and idle-bus noise
        rand_free = 1'b1;
        spurious = 1'b1;
        for (int r = 0; r < 10; r++) begin
            ack_pct = $urandom_range(100, 40);
            start_run({14'd0, 16'($urandom_range(16'hffff, 0)), 2'b00},
                      int'($urandom_range(12, 1)), int'($urandom_range(6, 1)),
                      int'($urandom_range(4, 1)));
            finish_run();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
